imx_cbu_burst: RTL and testbench
================================

// Module: imx_cbu_burst
// PURPOSE
//  Parametrised core bridge: converts one core IMX request into WISHBONE classic/registered-burst cycles.
//  Adds incrementing read bursts, bounded retry on wb_rty_i and a bus timeout.
//  Sits between the pippo core (fetch/LSU IMX master) and the on-chip WISHBONE fabric.
// PARAMETERS
//  DW       32   data width (bits); byte selects are DW/8 wide
//  AW       32   address width
//  BL       4    beats per read burst; power of 2, 2..16
//  TO_CYC   255  cycles without termination before timeout error; 1..2^16-1
//  RTY_MAX  3    retries allowed per beat before error; 0 = no retry
// PORTS
//  clk        in   1     core clock
//  rst        in   1     reset
//  cbu_rqt_i  in   1     core request valid; held until ack/err, drop = cancel
//  cbu_we_i   in   1     1 write, 0 read
//  cbu_bst_i  in   1     request BL-beat read burst (ignored when cbu_we_i=1)
//  cbu_adr_i  in   AW    request address (burst start, DW/8-aligned)
//  cbu_dat_i  in   DW    write data
//  cbu_sel_i  in   DW/8  byte selects
//  cbu_ack_o  out  1     one-cycle pulse per completed beat
//  cbu_err_o  out  1     one-cycle pulse: bus error, timeout or retry exhaustion
//  cbu_lst_o  out  1     with cbu_ack_o/cbu_err_o: final beat of transaction
//  cbu_dat_o  out  DW    read data of acked beat
//  cbu_adr_o  out  AW    address of acked/errored beat
//  wb_cyc_o, wb_stb_o, wb_we_o  out 1; wb_adr_o out AW; wb_sel_o out DW/8; wb_dat_o out DW
//  wb_cti_o   out  3     000 classic, 010 incr burst, 111 end of burst
//  wb_bte_o   out  2     always 00 (linear)
//  wb_ack_i, wb_err_i, wb_rty_i in 1; wb_dat_i in DW
// BEHAVIOUR
//  Reset: rst, asynchronous, active-high; clock clk. All outputs 0, FSM IDLE, counters 0.
//  FSM: IDLE -> BUS (rqt seen) ; BUS -> GAP (rty, retries left) ; GAP -> BUS (next cycle)
//       BUS -> IDLE (last ack, err, timeout, retry exhausted, or cancel).
//  IDLE: cbu_rqt_i=1 latches adr/we/sel/dat/mode; wb_cyc_o/wb_stb_o assert next cycle (1-cycle latency).
//  Burst iff cbu_bst_i=1 and cbu_we_i=0; beat counter 0..BL-1; cti=010, last beat cti=111; single cti=000.
//  Termination priority in same cycle: err > ack > rty.
//  ack: cbu_ack_o=1 next cycle, cbu_dat_o=wb_dat_i, cbu_adr_o=beat addr; burst adr += DW/8,
//   stb stays high (no gap between beats); cbu_lst_o=1 on final beat, then cyc/stb drop.
//  err: cbu_err_o=1, cbu_lst_o=1 next cycle, cyc/stb drop, remaining beats abandoned.
//  rty: cyc/stb drop for exactly one GAP cycle, same beat reissued; retry count per beat,
//   reset on ack; rty when count=RTY_MAX -> treated as err.
//  timeout: counter clears on any termination/new beat, +1 each BUS cycle; reaching TO_CYC -> err.
//  cancel: cbu_rqt_i=0 in BUS/GAP -> cyc/stb drop next cycle, no ack/err to core, wb ack in that
//   cycle discarded; FSM IDLE.
//  Back-to-back: after last beat one idle bus cycle minimum before next cyc.
//  Address arithmetic wraps modulo 2^AW; no 1KB boundary check (master aligns).
//  wb_* outputs and cbu_* outputs registered; wb_dat_o/wb_adr_o/wb_sel_o 0 whenever cyc=0.
// STRUCTURE
//  def_pippo.v gains `WB_CTI_CLASSIC/`WB_CTI_INCR/`WB_CTI_EOB and FSM state encodings.
//  Sub-module imx_cbu_tmo: loadable TO_CYC timeout counter with clear/enable/expire.
// TESTING
//  single read adr=0x100, ack after 2 cycles, dat=0xDEADBEEF -> cyc 1 cycle after rqt, cbu_ack_o+lst, adr_o=0x100
//  burst read BL=4 adr=0x200 -> cti 010,010,010,111; adr_o 0x200..0x20C; lst only on 4th ack
//  rty twice then ack, RTY_MAX=3 -> two 1-cycle cyc gaps, one ack; 4 rty -> cbu_err_o, no ack
//  no response, TO_CYC=8 -> cbu_err_o 9 cycles after cyc, cyc deasserts
//  cancel at burst beat 2 -> cyc drops next cycle, no further cbu_ack_o, next rqt accepted
//  err+ack same cycle -> err only; rst asserted mid-burst -> all outputs 0 immediately

Source files
------------

// File: rtl/imx_cbu_burst_pkg.sv
// rtl/imx_cbu_burst_pkg.sv - shared cycle-type codes and FSM states for the IMX to WISHBONE bridge
package imx_cbu_burst_pkg;

   localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
   localparam logic [2:0] WB_CTI_INCR    = 3'b010;
   localparam logic [2:0] WB_CTI_EOB     = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_GAP  = 2'd2
   } cbu_state_e;

   function automatic logic [2:0] beat_cti(input logic burst, input logic last);
      if (!burst) return WB_CTI_CLASSIC;
      return last ? WB_CTI_EOB : WB_CTI_INCR;
   endfunction

endpackage

// File: rtl/imx_cbu_burst_if.sv
// rtl/imx_cbu_burst_if.sv - core IMX request signals and WISHBONE master signals of the bridge
interface imx_cbu_burst_if #(
   parameter int DW = 32,
   parameter int AW = 32
);
   logic            cbu_rqt_i;
   logic            cbu_we_i;
   logic            cbu_bst_i;
   logic [AW-1:0]   cbu_adr_i;
   logic [DW-1:0]   cbu_dat_i;
   logic [DW/8-1:0] cbu_sel_i;
   logic            cbu_ack_o;
   logic            cbu_err_o;
   logic            cbu_lst_o;
   logic [DW-1:0]   cbu_dat_o;
   logic [AW-1:0]   cbu_adr_o;

   logic            wb_cyc_o;
   logic            wb_stb_o;
   logic            wb_we_o;
   logic [AW-1:0]   wb_adr_o;
   logic [DW/8-1:0] wb_sel_o;
   logic [DW-1:0]   wb_dat_o;
   logic [2:0]      wb_cti_o;
   logic [1:0]      wb_bte_o;
   logic            wb_ack_i;
   logic            wb_err_i;
   logic            wb_rty_i;
   logic [DW-1:0]   wb_dat_i;

   // master: the bridge itself; slave: core plus WISHBONE fabric around it
   modport master (
      input  cbu_rqt_i, cbu_we_i, cbu_bst_i, cbu_adr_i, cbu_dat_i, cbu_sel_i,
      output cbu_ack_o, cbu_err_o, cbu_lst_o, cbu_dat_o, cbu_adr_o,
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o, wb_cti_o, wb_bte_o,
      input  wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
   );

   modport slave (
      output cbu_rqt_i, cbu_we_i, cbu_bst_i, cbu_adr_i, cbu_dat_i, cbu_sel_i,
      input  cbu_ack_o, cbu_err_o, cbu_lst_o, cbu_dat_o, cbu_adr_o,
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o, wb_cti_o, wb_bte_o,
      output wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
   );

endinterface

// File: rtl/imx_cbu_burst_tmo.sv
// rtl/imx_cbu_burst_tmo.sv - loadable down-counter flagging a WISHBONE beat left unterminated
module imx_cbu_burst_tmo #(
   parameter int TO_CYC = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic ld_i,
   input  logic en_i,
   output logic exp_o
);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (ld_i)
         cnt_d = 16'(TO_CYC);
      else if (en_i && cnt_q != 16'd0)
         cnt_d = cnt_q - 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign exp_o = (cnt_q == 16'd0);

endmodule

// File: rtl/imx_cbu_burst.sv
// rtl/imx_cbu_burst.sv - IMX request to WISHBONE classic/incrementing-burst bridge
// with bounded retry and bus timeout.
module imx_cbu_burst
   import imx_cbu_burst_pkg::*;
#(
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int BL      = 4,
   parameter int TO_CYC  = 255,
   parameter int RTY_MAX = 3
) (
   input logic             clk,
   input logic             rst,
   imx_cbu_burst_if.master bus
);

   localparam int SB = DW / 8;
   localparam int BW = $clog2(BL);
   localparam int RW = $clog2(RTY_MAX + 2);

   cbu_state_e      state_q, state_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic [RW-1:0]   rty_q, rty_d;
   logic [AW-1:0]   req_adr_q, req_adr_d;
   logic [DW-1:0]   req_dat_q, req_dat_d;
   logic [SB-1:0]   req_sel_q, req_sel_d;
   logic            req_we_q, req_we_d;
   logic            bst_q, bst_d;

   logic            wb_cyc_q, wb_cyc_d;
   logic            wb_stb_q, wb_stb_d;
   logic            wb_we_q, wb_we_d;
   logic [AW-1:0]   wb_adr_q, wb_adr_d;
   logic [SB-1:0]   wb_sel_q, wb_sel_d;
   logic [DW-1:0]   wb_dat_q, wb_dat_d;
   logic [2:0]      wb_cti_q, wb_cti_d;

   logic            cbu_ack_q, cbu_ack_d;
   logic            cbu_err_q, cbu_err_d;
   logic            cbu_lst_q, cbu_lst_d;
   logic [DW-1:0]   cbu_dat_q, cbu_dat_d;
   logic [AW-1:0]   cbu_adr_q, cbu_adr_d;

   logic            issue, drop, fail, tmo_ld, tmo_exp;

   imx_cbu_burst_tmo #(.TO_CYC(TO_CYC)) u_tmo (
      .clk   (clk),
      .rst   (rst),
      .ld_i  (tmo_ld),
      .en_i  (state_q == ST_BUS),
      .exp_o (tmo_exp)
   );

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      rty_d     = rty_q;
      req_adr_d = req_adr_q;
      req_dat_d = req_dat_q;
      req_sel_d = req_sel_q;
      req_we_d  = req_we_q;
      bst_d     = bst_q;
      wb_cyc_d  = wb_cyc_q;
      wb_stb_d  = wb_stb_q;
      wb_we_d   = wb_we_q;
      wb_adr_d  = wb_adr_q;
      wb_sel_d  = wb_sel_q;
      wb_dat_d  = wb_dat_q;
      wb_cti_d  = wb_cti_q;
      cbu_ack_d = 1'b0;
      cbu_err_d = 1'b0;
      cbu_lst_d = 1'b0;
      cbu_dat_d = cbu_dat_q;
      cbu_adr_d = cbu_adr_q;
      issue     = 1'b0;
      drop      = 1'b0;
      fail      = 1'b0;
      tmo_ld    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // cbu_lst_q high means the core is still seeing the final pulse, so its rqt is stale
            if (bus.cbu_rqt_i && !cbu_lst_q) begin
               req_adr_d = bus.cbu_adr_i;
               req_dat_d = bus.cbu_dat_i;
               req_sel_d = bus.cbu_sel_i;
               req_we_d  = bus.cbu_we_i;
               bst_d     = bus.cbu_bst_i & ~bus.cbu_we_i;
               beat_d    = '0;
               rty_d     = '0;
               state_d   = ST_BUS;
               issue     = 1'b1;
            end
         end
         ST_BUS: begin
            if (!bus.cbu_rqt_i) begin
               state_d = ST_IDLE;
               drop    = 1'b1;
            end else if (bus.wb_err_i) begin
               fail = 1'b1;
            end else if (bus.wb_ack_i) begin
               cbu_ack_d = 1'b1;
               cbu_dat_d = bus.wb_dat_i;
               cbu_adr_d = req_adr_q;
               rty_d     = '0;
               if (bst_q && beat_q != BW'(BL - 1)) begin
                  beat_d    = beat_q + BW'(1);
                  req_adr_d = req_adr_q + AW'(SB);
                  issue     = 1'b1;
               end else begin
                  cbu_lst_d = 1'b1;
                  state_d   = ST_IDLE;
                  drop      = 1'b1;
               end
            end else if (bus.wb_rty_i) begin
               if (rty_q == RW'(RTY_MAX)) begin
                  fail = 1'b1;
               end else begin
                  rty_d   = rty_q + RW'(1);
                  state_d = ST_GAP;
                  drop    = 1'b1;
               end
            end else if (tmo_exp) begin
               fail = 1'b1;
            end
         end
         ST_GAP: begin
            if (!bus.cbu_rqt_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_BUS;
               issue   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (fail) begin
         cbu_err_d = 1'b1;
         cbu_lst_d = 1'b1;
         cbu_adr_d = req_adr_q;
         state_d   = ST_IDLE;
         drop      = 1'b1;
      end

      if (issue) begin
         wb_cyc_d = 1'b1;
         wb_stb_d = 1'b1;
         wb_we_d  = req_we_d;
         wb_adr_d = req_adr_d;
         wb_sel_d = req_sel_d;
         wb_dat_d = req_dat_d;
         wb_cti_d = beat_cti(bst_d, beat_d == BW'(BL - 1));
         tmo_ld   = 1'b1;
      end

      // address/data/select are forced to zero whenever the cycle is released
      if (drop) begin
         wb_cyc_d = 1'b0;
         wb_stb_d = 1'b0;
         wb_we_d  = 1'b0;
         wb_adr_d = '0;
         wb_sel_d = '0;
         wb_dat_d = '0;
         wb_cti_d = WB_CTI_CLASSIC;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         beat_q    <= '0;
         rty_q     <= '0;
         req_adr_q <= '0;
         req_dat_q <= '0;
         req_sel_q <= '0;
         req_we_q  <= 1'b0;
         bst_q     <= 1'b0;
         wb_cyc_q  <= 1'b0;
         wb_stb_q  <= 1'b0;
         wb_we_q   <= 1'b0;
         wb_adr_q  <= '0;
         wb_sel_q  <= '0;
         wb_dat_q  <= '0;
         wb_cti_q  <= '0;
         cbu_ack_q <= 1'b0;
         cbu_err_q <= 1'b0;
         cbu_lst_q <= 1'b0;
         cbu_dat_q <= '0;
         cbu_adr_q <= '0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         rty_q     <= rty_d;
         req_adr_q <= req_adr_d;
         req_dat_q <= req_dat_d;
         req_sel_q <= req_sel_d;
         req_we_q  <= req_we_d;
         bst_q     <= bst_d;
         wb_cyc_q  <= wb_cyc_d;
         wb_stb_q  <= wb_stb_d;
         wb_we_q   <= wb_we_d;
         wb_adr_q  <= wb_adr_d;
         wb_sel_q  <= wb_sel_d;
         wb_dat_q  <= wb_dat_d;
         wb_cti_q  <= wb_cti_d;
         cbu_ack_q <= cbu_ack_d;
         cbu_err_q <= cbu_err_d;
         cbu_lst_q <= cbu_lst_d;
         cbu_dat_q <= cbu_dat_d;
         cbu_adr_q <= cbu_adr_d;
      end
   end

   assign bus.wb_cyc_o  = wb_cyc_q;
   assign bus.wb_stb_o  = wb_stb_q;
   assign bus.wb_we_o   = wb_we_q;
   assign bus.wb_adr_o  = wb_adr_q;
   assign bus.wb_sel_o  = wb_sel_q;
   assign bus.wb_dat_o  = wb_dat_q;
   assign bus.wb_cti_o  = wb_cti_q;
   assign bus.wb_bte_o  = 2'b00;
   assign bus.cbu_ack_o = cbu_ack_q;
   assign bus.cbu_err_o = cbu_err_q;
   assign bus.cbu_lst_o = cbu_lst_q;
   assign bus.cbu_dat_o = cbu_dat_q;
   assign bus.cbu_adr_o = cbu_adr_q;

endmodule

// File: tb/tb_imx_cbu_burst.sv
// tb/tb_imx_cbu_burst.sv - directed self-checking bench for imx_cbu_burst (BL=4, TO_CYC=8, RTY_MAX=3)
module tb_imx_cbu_burst;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_tot;

   imx_cbu_burst_if #(.DW(32), .AW(32)) bus_if();

   imx_cbu_burst #(
      .DW(32), .AW(32), .BL(4), .TO_CYC(8), .RTY_MAX(3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      bus_if.cbu_rqt_i = 1'b0;
      bus_if.cbu_we_i  = 1'b0;
      bus_if.cbu_bst_i = 1'b0;
      bus_if.cbu_adr_i = '0;
      bus_if.cbu_dat_i = '0;
      bus_if.cbu_sel_i = '0;
      bus_if.wb_ack_i  = 1'b0;
      bus_if.wb_err_i  = 1'b0;
      bus_if.wb_rty_i  = 1'b0;
      bus_if.wb_dat_i  = '0;
   endtask

   task automatic request(input logic we, input logic bst, input logic [31:0] adr, input logic [31:0] dat);
      bus_if.cbu_rqt_i = 1'b1;
      bus_if.cbu_we_i  = we;
      bus_if.cbu_bst_i = bst;
      bus_if.cbu_adr_i = adr;
      bus_if.cbu_dat_i = dat;
      bus_if.cbu_sel_i = 4'hF;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      n_tot++;
      if (bus_if.wb_cyc_o !== 1'b0 || bus_if.wb_stb_o !== 1'b0)
         $display("FAIL reset_cyc_stb: got %0b%0b want 00", bus_if.wb_cyc_o, bus_if.wb_stb_o);
      else n_pass++;
      n_tot++;
      if ({bus_if.cbu_ack_o, bus_if.cbu_err_o, bus_if.cbu_lst_o} !== 3'b000)
         $display("FAIL reset_cbu_flags: got %0b%0b%0b want 000", bus_if.cbu_ack_o, bus_if.cbu_err_o, bus_if.cbu_lst_o);
      else n_pass++;
      n_tot++;
      if (bus_if.wb_adr_o !== 32'h0 || bus_if.wb_cti_o !== 3'b000 || bus_if.wb_bte_o !== 2'b00)
         $display("FAIL reset_wb_fields: got adr=%0h cti=%0b bte=%0b want 0", bus_if.wb_adr_o, bus_if.wb_cti_o, bus_if.wb_bte_o);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_read();
      request(1'b0, 1'b0, 32'h100, 32'h0);
      #1;
      n_tot++;
      if (bus_if.wb_cyc_o !== 1'b0) $display("FAIL single_no_comb_cyc: got %0b want 0", bus_if.wb_cyc_o);
      else n_pass++;
      @(negedge clk);
      n_tot++;
      if (bus_if.wb_cyc_o !== 1'b1 || bus_if.wb_stb_o !== 1'b1 || bus_if.wb_we_o !== 1'b0)
         $display("FAIL single_cyc_latency: got cyc=%0b stb=%0b we=%0b want 1 1 0", bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.wb_we_o);
      else n_pass++;
      n_tot++;
      if (bus_if.wb_adr_o !== 32'h100 || bus_if.wb_cti_o !== 3'b000)
         $display("FAIL single_adr_cti: got adr=%0h cti=%0b want 100 000", bus_if.wb_adr_o, bus_if.wb_cti_o);
      else n_pass++;
      @(negedge clk);
      bus_if.wb_ack_i = 1'b1;
      bus_if.wb_dat_i = 32'hDEADBEEF;
      @(negedge clk);
      bus_if.wb_ack_i = 1'b0;
      n_tot++;
      if (bus_if.cbu_ack_o !== 1'b1 || bus_if.cbu_lst_o !== 1'b1 || bus_if.cbu_err_o !== 1'b0)
         $display("FAIL single_ack_lst: got ack=%0b lst=%0b err=%0b want 1 1 0", bus_if.cbu_ack_o, bus_if.cbu_lst_o, bus_if.cbu_err_o);
      else n_pass++;
      n_tot++;
      if (bus_if.cbu_dat_o !== 32'hDEADBEEF || bus_if.cbu_adr_o !== 32'h100)
         $display("FAIL single_dat_adr: got dat=%0h adr=%0h want deadbeef 100", bus_if.cbu_dat_o, bus_if.cbu_adr_o);
      else n_pass++;
      n_tot++;
      if (bus_if.wb_cyc_o !== 1'b0 || bus_if.wb_adr_o !== 32'h0)
         $display("FAIL single_release: got cyc=%0b adr=%0h want 0 0", bus_if.wb_cyc_o, bus_if.wb_adr_o);
      else n_pass++;
      bus_if.cbu_rqt_i = 1'b0;
      @(negedge clk);
      n_tot++;
      if (bus_if.cbu_ack_o !== 1'b0) $display("FAIL single_ack_pulse: got %0b want 0", bus_if.cbu_ack_o);
      else n_pass++;
   endtask

   task automatic test_burst_read();
      logic [2:0] cti_exp [4];
      cti_exp = '{3'b010, 3'b010, 3'b010, 3'b111};
      request(1'b0, 1'b1, 32'h200, 32'h0);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         n_tot++;
         if (bus_if.wb_cyc_o !== 1'b1 || bus_if.wb_cti_o !== cti_exp[i] || bus_if.wb_adr_o !== 32'h200 + 32'(4 * i))
            $display("FAIL burst_beat%0d_wb: got cyc=%0b cti=%0b adr=%0h want 1 %0b %0h",
                     i, bus_if.wb_cyc_o, bus_if.wb_cti_o, bus_if.wb_adr_o, cti_exp[i], 32'h200 + 32'(4 * i));
         else n_pass++;
         bus_if.wb_ack_i = 1'b1;
         bus_if.wb_dat_i = 32'hB0B00000 + 32'(i);
         @(negedge clk);
         n_tot++;
         if (bus_if.cbu_ack_o !== 1'b1 || bus_if.cbu_lst_o !== (i == 3) ||
             bus_if.cbu_adr_o !== 32'h200 + 32'(4 * i) || bus_if.cbu_dat_o !== 32'hB0B00000 + 32'(i))
            $display("FAIL burst_beat%0d_cbu: got ack=%0b lst=%0b adr=%0h dat=%0h want 1 %0b %0h %0h",
                     i, bus_if.cbu_ack_o, bus_if.cbu_lst_o, bus_if.cbu_adr_o, bus_if.cbu_dat_o,
                     (i == 3), 32'h200 + 32'(4 * i), 32'hB0B00000 + 32'(i));
         else n_pass++;
      end
      bus_if.wb_ack_i = 1'b0;
      n_tot++;
      if (bus_if.wb_cyc_o !== 1'b0) $display("FAIL burst_end_cyc: got %0b want 0", bus_if.wb_cyc_o);
      else n_pass++;
      bus_if.cbu_rqt_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      request(1'b1, 1'b0, 32'h180, 32'h12345678);
      @(negedge clk);
      n_tot++;
      if (bus_if.wb_we_o !== 1'b1 || bus_if.wb_dat_o !== 32'h12345678 || bus_if.wb_sel_o !== 4'hF)
         $display("FAIL b2b_write_fields: got we=%0b dat=%0h sel=%0h want 1 12345678 f", bus_if.wb_we_o, bus_if.wb_dat_o, bus_if.wb_sel_o);
      else n_pass++;
      bus_if.wb_ack_i = 1'b1;
      @(negedge clk);
      bus_if.wb_ack_i = 1'b0;
      request(1'b0, 1'b0, 32'h1C0, 32'h0);
      @(negedge clk);
      n_tot++;
      if (bus_if.wb_cyc_o !== 1'b0) $display("FAIL b2b_idle_gap: got %0b want 0", bus_if.wb_cyc_o);
      else n_pass++;
      @(negedge clk);
      n_tot++;
      if (bus_if.wb_cyc_o !== 1'b1 || bus_if.wb_adr_o !== 32'h1C0 || bus_if.wb_we_o !== 1'b0)
         $display("FAIL b2b_second: got cyc=%0b adr=%0h we=%0b want 1 1c0 0", bus_if.wb_cyc_o, bus_if.wb_adr_o, bus_if.wb_we_o);
      else n_pass++;
      bus_if.wb_ack_i = 1'b1;
      @(negedge clk);
      bus_if.wb_ack_i  = 1'b0;
      bus_if.cbu_rqt_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_retry();
      int acks;
      acks = 0;
      request(1'b0, 1'b0, 32'h300, 32'h0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_tot++;
         if (bus_if.wb_cyc_o !== 1'b1 || bus_if.wb_adr_o !== 32'h300)
            $display("FAIL rty_reissue%0d: got cyc=%0b adr=%0h want 1 300", k, bus_if.wb_cyc_o, bus_if.wb_adr_o);
         else n_pass++;
         bus_if.wb_rty_i = 1'b1;
         @(negedge clk);
         bus_if.wb_rty_i = 1'b0;
         n_tot++;
         if (bus_if.wb_cyc_o !== 1'b0 || bus_if.cbu_ack_o !== 1'b0 || bus_if.cbu_err_o !== 1'b0)
            $display("FAIL rty_gap%0d: got cyc=%0b ack=%0b err=%0b want 0 0 0", k, bus_if.wb_cyc_o, bus_if.cbu_ack_o, bus_if.cbu_err_o);
         else n_pass++;
      end
      @(negedge clk);
      bus_if.wb_ack_i = 1'b1;
      bus_if.wb_dat_i = 32'h0000CAFE;
      @(negedge clk);
      bus_if.wb_ack_i = 1'b0;
      if (bus_if.cbu_ack_o === 1'b1) acks++;
      bus_if.cbu_rqt_i = 1'b0;
      @(negedge clk);
      if (bus_if.cbu_ack_o === 1'b1) acks++;
      n_tot++;
      if (acks !== 1) $display("FAIL rty_one_ack: got %0d want 1", acks);
      else n_pass++;

      request(1'b0, 1'b0, 32'h340, 32'h0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus_if.wb_rty_i = 1'b1;
         @(negedge clk);
         bus_if.wb_rty_i = 1'b0;
         if (k < 3) begin
            n_tot++;
            if (bus_if.wb_cyc_o !== 1'b0 || bus_if.cbu_err_o !== 1'b0)
               $display("FAIL rty_ex_gap%0d: got cyc=%0b err=%0b want 0 0", k, bus_if.wb_cyc_o, bus_if.cbu_err_o);
            else n_pass++;
         end
      end
      n_tot++;
      if (bus_if.cbu_err_o !== 1'b1 || bus_if.cbu_lst_o !== 1'b1 || bus_if.cbu_ack_o !== 1'b0 ||
          bus_if.cbu_adr_o !== 32'h340 || bus_if.wb_cyc_o !== 1'b0)
         $display("FAIL rty_exhaust: got err=%0b lst=%0b ack=%0b adr=%0h cyc=%0b want 1 1 0 340 0",
                  bus_if.cbu_err_o, bus_if.cbu_lst_o, bus_if.cbu_ack_o, bus_if.cbu_adr_o, bus_if.wb_cyc_o);
      else n_pass++;
      bus_if.cbu_rqt_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int n;
      request(1'b0, 1'b0, 32'h400, 32'h0);
      @(negedge clk);
      n_tot++;
      if (bus_if.wb_cyc_o !== 1'b1) $display("FAIL tmo_cyc: got %0b want 1", bus_if.wb_cyc_o);
      else n_pass++;
      n = 0;
      while (n < 20 && bus_if.cbu_err_o !== 1'b1) begin
         @(negedge clk);
         n++;
      end
      n_tot++;
      if (n !== 9) $display("FAIL tmo_latency: got %0d want 9", n);
      else n_pass++;
      n_tot++;
      if (bus_if.wb_cyc_o !== 1'b0 || bus_if.cbu_lst_o !== 1'b1 || bus_if.cbu_adr_o !== 32'h400)
         $display("FAIL tmo_err_state: got cyc=%0b lst=%0b adr=%0h want 0 1 400", bus_if.wb_cyc_o, bus_if.cbu_lst_o, bus_if.cbu_adr_o);
      else n_pass++;
      bus_if.cbu_rqt_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_cancel();
      request(1'b0, 1'b1, 32'h500, 32'h0);
      @(negedge clk);
      bus_if.wb_ack_i = 1'b1;
      bus_if.wb_dat_i = 32'h55;
      repeat (2) @(negedge clk);
      n_tot++;
      if (bus_if.wb_adr_o !== 32'h508 || bus_if.wb_cyc_o !== 1'b1)
         $display("FAIL cancel_beat2: got adr=%0h cyc=%0b want 508 1", bus_if.wb_adr_o, bus_if.wb_cyc_o);
      else n_pass++;
      bus_if.cbu_rqt_i = 1'b0;
      @(negedge clk);
      bus_if.wb_ack_i = 1'b0;
      n_tot++;
      if (bus_if.wb_cyc_o !== 1'b0 || bus_if.cbu_ack_o !== 1'b0 || bus_if.cbu_err_o !== 1'b0)
         $display("FAIL cancel_drop: got cyc=%0b ack=%0b err=%0b want 0 0 0", bus_if.wb_cyc_o, bus_if.cbu_ack_o, bus_if.cbu_err_o);
      else n_pass++;
      @(negedge clk);
      n_tot++;
      if (bus_if.wb_cyc_o !== 1'b0 || bus_if.cbu_ack_o !== 1'b0)
         $display("FAIL cancel_quiet: got cyc=%0b ack=%0b want 0 0", bus_if.wb_cyc_o, bus_if.cbu_ack_o);
      else n_pass++;
      request(1'b0, 1'b0, 32'h600, 32'h0);
      @(negedge clk);
      n_tot++;
      if (bus_if.wb_cyc_o !== 1'b1 || bus_if.wb_adr_o !== 32'h600 || bus_if.wb_cti_o !== 3'b000)
         $display("FAIL cancel_next_rqt: got cyc=%0b adr=%0h cti=%0b want 1 600 000", bus_if.wb_cyc_o, bus_if.wb_adr_o, bus_if.wb_cti_o);
      else n_pass++;
      bus_if.wb_ack_i = 1'b1;
      bus_if.wb_dat_i = 32'h66;
      @(negedge clk);
      bus_if.wb_ack_i = 1'b0;
      n_tot++;
      if (bus_if.cbu_ack_o !== 1'b1 || bus_if.cbu_adr_o !== 32'h600 || bus_if.cbu_dat_o !== 32'h66)
         $display("FAIL cancel_next_ack: got ack=%0b adr=%0h dat=%0h want 1 600 66", bus_if.cbu_ack_o, bus_if.cbu_adr_o, bus_if.cbu_dat_o);
      else n_pass++;
      bus_if.cbu_rqt_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_err_ack();
      request(1'b0, 1'b0, 32'h700, 32'h0);
      @(negedge clk);
      bus_if.wb_err_i = 1'b1;
      bus_if.wb_ack_i = 1'b1;
      @(negedge clk);
      bus_if.wb_err_i = 1'b0;
      bus_if.wb_ack_i = 1'b0;
      n_tot++;
      if (bus_if.cbu_err_o !== 1'b1 || bus_if.cbu_ack_o !== 1'b0 || bus_if.cbu_lst_o !== 1'b1 || bus_if.wb_cyc_o !== 1'b0)
         $display("FAIL err_over_ack: got err=%0b ack=%0b lst=%0b cyc=%0b want 1 0 1 0",
                  bus_if.cbu_err_o, bus_if.cbu_ack_o, bus_if.cbu_lst_o, bus_if.wb_cyc_o);
      else n_pass++;
      bus_if.cbu_rqt_i = 1'b0;
      @(negedge clk);
      n_tot++;
      if (bus_if.cbu_err_o !== 1'b0) $display("FAIL err_pulse: got %0b want 0", bus_if.cbu_err_o);
      else n_pass++;
   endtask

   task automatic test_reset_mid_burst();
      request(1'b0, 1'b1, 32'h800, 32'h0);
      @(negedge clk);
      bus_if.wb_ack_i = 1'b1;
      bus_if.wb_dat_i = 32'h88;
      @(negedge clk);
      n_tot++;
      if (bus_if.cbu_ack_o !== 1'b1 || bus_if.wb_adr_o !== 32'h804)
         $display("FAIL rstmid_pre: got ack=%0b adr=%0h want 1 804", bus_if.cbu_ack_o, bus_if.wb_adr_o);
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_tot++;
      if (bus_if.wb_cyc_o !== 1'b0 || bus_if.wb_stb_o !== 1'b0 || bus_if.wb_adr_o !== 32'h0 || bus_if.wb_cti_o !== 3'b000)
         $display("FAIL rstmid_wb: got cyc=%0b stb=%0b adr=%0h cti=%0b want 0 0 0 0",
                  bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.wb_adr_o, bus_if.wb_cti_o);
      else n_pass++;
      n_tot++;
      if (bus_if.cbu_ack_o !== 1'b0 || bus_if.cbu_dat_o !== 32'h0 || bus_if.cbu_adr_o !== 32'h0)
         $display("FAIL rstmid_cbu: got ack=%0b dat=%0h adr=%0h want 0 0 0", bus_if.cbu_ack_o, bus_if.cbu_dat_o, bus_if.cbu_adr_o);
      else n_pass++;
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_tot++;
      if (bus_if.wb_cyc_o !== 1'b0) $display("FAIL rstmid_after: got %0b want 0", bus_if.wb_cyc_o);
      else n_pass++;
   endtask

   initial begin
      n_pass = 0;
      n_tot  = 0;
      rst    = 1'b1;
      idle_inputs();
      test_reset();
      test_single_read();
      test_burst_read();
      test_back_to_back();
      test_retry();
      test_timeout();
      test_cancel();
      test_err_ack();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
